// File: rtl/instr_encoder_if.sv
// Handshake and write-port bundle between the program loader, the instruction encoder and instruction RAM.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              EncValid;
  logic              EncReady;
  logic [7:0]        OpCode;
  logic [2:0]        FieldX;
  logic [2:0]        FieldY;
  logic [2:0]        FieldZ;
  logic [23:0]       Literal;
  logic              InstrWe;
  logic [ADDR_W-1:0] InstrAddr;
  logic [31:0]       InstrWord;

  modport slave (
    input  EncValid, OpCode, FieldX, FieldY, FieldZ, Literal,
    output EncReady, InstrWe, InstrAddr, InstrWord
  );

  modport master (
    output EncValid, OpCode, FieldX, FieldY, FieldZ, Literal,
    input  EncReady, InstrWe, InstrAddr, InstrWord
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs opcode/register/literal fields into decoder-format words and writes them sequentially.
// Optional running XOR checksum of written words is enabled by defining ENC_CHECKSUM_EN.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Stop,
  input  logic [ADDR_W-1:0] BaseAddr,
  instr_encoder_if.slave    enc,
  output logic [ADDR_W:0]   WordCount,
  output logic              Busy,
  output logic              EncError,
  output logic [31:0]       Checksum
);

  // state  | meaning
  // S_IDLE | no session, input blocked
  // S_RUN  | session open, accepting field sets
  // S_FULL | top address written, input blocked
  // S_ERR  | illegal request seen, input blocked
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_word;
  logic              r_err;
  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_ready;
  logic              w_acc;
  logic              w_ill;
  logic              w_start;

  always_comb begin
    w_word       = 32'd0;
    w_legal      = 1'b1;
    w_word[7:0]  = enc.OpCode;
    case (enc.OpCode)
      8'd1, 8'd2, 8'd5, 8'd6, 8'd9, 8'd11, 8'd23, 8'd24, 8'd26, 8'd27, 8'd28,
      8'd29, 8'd30, 8'd33, 8'd37, 8'd40, 8'd41:
        w_word[31:8] = enc.Literal;
      8'd3, 8'd4, 8'd7, 8'd8, 8'd10, 8'd12, 8'd31, 8'd32, 8'd39, 8'd42, 8'd44,
      8'd45, 8'd48: begin
        w_word[10:8]  = enc.FieldX;
        w_word[13:11] = enc.FieldY;
        w_word[16:14] = enc.FieldZ;
      end
      8'd13, 8'd14, 8'd15, 8'd16: begin
        w_word[10:8]  = enc.FieldX;
        w_word[16:11] = enc.Literal[5:0];
        w_legal       = (enc.Literal[23:6] == 18'd0);
      end
      8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd22, 8'd38: begin
        w_word[10:8]  = enc.FieldX;
        w_word[13:11] = enc.FieldY;
      end
      8'd25, 8'd34: w_word[10:8] = enc.FieldX;
      8'd35, 8'd46: w_word[10:8] = enc.FieldZ;
      8'd36, 8'd49: begin
        w_word[10:8]  = enc.FieldZ;
        w_word[13:11] = enc.FieldY;
      end
      8'd255:  w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_ready = (r_state == S_RUN);
  assign w_acc   = enc.EncValid && w_ready && w_legal;
  assign w_ill   = enc.EncValid && w_ready && !w_legal;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (Start) w_next = S_RUN;
      S_RUN: begin
        if (w_ill)                          w_next = S_ERR;
        else if (Stop)                      w_next = S_IDLE;
        else if (w_acc && r_ptr == LAST_ADDR) w_next = S_FULL;
      end
      default: begin
        if (Stop)       w_next = S_IDLE;
        else if (Start) w_next = S_RUN;
      end
    endcase
  end

  assign w_start = (r_state != S_RUN) && (w_next == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= w_acc;
      if (w_start) begin
        r_ptr <= BaseAddr;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_acc) begin
        r_addr <= r_ptr;
        r_word <= w_word;
        r_ptr  <= r_ptr + ADDR_W'(1);
        r_cnt  <= r_cnt + (ADDR_W+1)'(1);
      end else if (w_ill) begin
        r_err <= 1'b1;
      end
    end
  end

  assign enc.EncReady  = w_ready;
  assign enc.InstrWe   = r_we;
  assign enc.InstrAddr = r_addr;
  assign enc.InstrWord = r_word;
  assign WordCount     = r_cnt;
  assign Busy          = w_ready;
  assign EncError      = r_err;

`ifdef ENC_CHECKSUM_EN
  logic [31:0] r_csum;

  // Updated alongside r_word so the value already includes the word being strobed out.
  always_ff @(posedge clk) begin
    if (!rst)         r_csum <= 32'd0;
    else if (w_start) r_csum <= 32'd0;
    else if (w_acc)   r_csum <= r_csum ^ w_word;
  end

  assign Checksum = r_csum;
`else
  assign Checksum = 32'd0;
`endif

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Program-load encoder: packs opcode/register/literal fields into 32-bit instruction words using the exact field layout the CPU decoder expects, and writes them sequentially into instruction memory. It sits between the host/debug loader and the instruction RAM and is the write-side counterpart of the decode stage. A small FSM controls each load session, with a valid/ready input handshake and a one-stage registered write port.

Parameters:
ADDR_W, 8, instruction memory address width
MEM_DEPTH, 256, number of writable words; last address = MEM_DEPTH-1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
Start  in  1  pulse: begin session at BaseAddr
Stop  in  1  pulse: end session
BaseAddr  in  ADDR_W  first write address
EncValid  in  1  field set valid
EncReady  out  1  encoder accepts this cycle
OpCode  in  8  instruction opcode
FieldX  in  3  Rx
FieldY  in  3  Ry
FieldZ  in  3  Rz
Literal  in  24  immediate
InstrWe  out  1  memory write strobe
InstrAddr  out  ADDR_W  write address
InstrWord  out  32  encoded instruction
WordCount  out  ADDR_W+1  words written this session
Busy  out  1  state==RUN
EncError  out  1  sticky error
Checksum  out  32  see Optional Feature

Behaviour:
- Reset (rst==0): state IDLE; EncReady, InstrWe, Busy, EncError = 0; InstrAddr, InstrWord, WordCount, Checksum = 0. Any pending write is dropped (InstrWe=0 on the cycle after reset).
- States: IDLE, RUN, FULL, ERR.
  - IDLE -Start-> RUN: write pointer <= BaseAddr, WordCount <= 0, EncError <= 0.
  - RUN -Stop-> IDLE.
  - RUN -> FULL after writing address MEM_DEPTH-1.
  - RUN -> ERR on an illegal request.
  - FULL or ERR -Stop-> IDLE.
  - FULL or ERR -Start-> RUN (same actions as IDLE -Start-> RUN; clears EncError).
- EncReady = (state==RUN); it is a combinational decode of state only.
- Handshake: a transfer occurs when EncValid && EncReady. On transfer in cycle N, InstrWe=1 in cycle N+1 with InstrWord and InstrAddr = pointer. The pointer and WordCount increment at the transfer. InstrWe is 0 in every cycle without a preceding transfer. Throughput is 1 word/cycle.
- Packing (all unspecified bits 0; bits [7:0] = OpCode in every case):
  - L24 (op 1,2,5,6,9,11,23,24,26,27,28,29,30,33,37,40,41): [31:8] = Literal.
  - XYZ (op 3,4,7,8,10,12,31,32,39,42,44,45,48): [10:8]=X, [13:11]=Y, [16:14]=Z.
  - XL6 (op 13-16): [10:8]=X, [16:11]=Literal[5:0]; Literal[23:6]!=0 is illegal.
  - XY (op 17-22,38): [10:8]=X, [13:11]=Y.
  - X (op 25,34): [10:8]=X.
  - Z (op 35,46): [10:8]=Z.
  - ZY (op 36,49): [10:8]=Z, [13:11]=Y.
  - RAW (op 255): [31:8]=0.
  - Any other opcode is illegal.
- Illegal request: no write (InstrWe stays 0), pointer and WordCount unchanged, EncError=1 from the next cycle, state ERR.
- Simultaneous events:
  - Start in RUN: ignored.
  - Stop and transfer in the same RUN cycle: the word is written, then state goes to IDLE.
  - Start and EncValid in IDLE: Start is taken; EncValid is not accepted because EncReady=0.
- Wrap-around: the pointer never wraps; state FULL blocks further input. A BaseAddr near the top of memory yields a shorter session.

Optional Feature:
ENC_CHECKSUM_EN
- Defined: Checksum is the running XOR of every written InstrWord. It is cleared on Start and on reset, and updates in the same cycle as InstrWe.
- Undefined: Checksum is tied to 32'd0 and no checksum logic is present.

Test Plan:
- Start with BaseAddr=0; op=3, X=1, Y=2, Z=3 -> next cycle InstrWe=1, InstrAddr=0, InstrWord=0x0000D103, WordCount=1.
- op=1, Literal=0xABCDEF, then op=13, X=5, Literal=0x2A, back-to-back -> words 0xABCDEF01 at addr 0 and 0x0001550D at addr 1 in consecutive cycles; with ENC_CHECKSUM_EN, Checksum=0xABCCBA0C.
- op=36, Z=4, Y=6 -> 0x00003424. op=50 -> no write, EncError=1, EncReady=0, state ERR; a following Start clears EncError.
- op=13, Literal=0x40 (out of 6-bit range) -> EncError=1, no write.
- BaseAddr=MEM_DEPTH-2; two transfers -> writes to 254 and 255, then EncReady=0 (FULL), WordCount=2; a third EncValid is not accepted.
- rst=0 asserted the cycle after a transfer -> InstrWe=0 on the next cycle, all outputs 0, state IDLE. Stop in the same cycle as a transfer -> word written, then Busy=0.
